// File: rtl/system_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and
// compares them against the build-time values.
module system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1393616007,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    FIN
  } state_t;

  localparam bit HAS_LAT = (READ_LATENCY > 0);
  localparam logic [2:0] LAT_LAST =
    HAS_LAT ? 3'(READ_LATENCY - 1) : 3'd0;
  localparam logic [15:0] STALL_LAST =
    16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] stall_q;
  logic [2:0]  lat_q;
  logic        cap_id;
  logic        cap_ts;
  logic        abort;
  logic        in_lat;
  logic        launch;

  assign in_lat = (state_q == LAT_ID) || (state_q == LAT_TS);
  assign launch = (state_q == IDLE) && start;

  // Next-state and bus/status decode
  always_comb begin
    state_d     = state_q;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    abort       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RD_ID;
      end
      RD_ID: begin
        avm_read = 1'b1;
        busy     = 1'b1;
        if (!avm_waitrequest) begin
          if (HAS_LAT) begin
            state_d = LAT_ID;
          end else begin
            cap_id  = 1'b1;
            state_d = RD_TS;
          end
        end else if (stall_q == STALL_LAST) begin
          abort   = 1'b1;
          state_d = FIN;
        end
      end
      LAT_ID: begin
        busy = 1'b1;
        if (lat_q == LAT_LAST) begin
          cap_id  = 1'b1;
          state_d = RD_TS;
        end
      end
      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        busy        = 1'b1;
        if (!avm_waitrequest) begin
          if (HAS_LAT) begin
            state_d = LAT_TS;
          end else begin
            cap_ts  = 1'b1;
            state_d = FIN;
          end
        end else if (stall_q == STALL_LAST) begin
          abort   = 1'b1;
          state_d = FIN;
        end
      end
      LAT_TS: begin
        busy = 1'b1;
        if (lat_q == LAT_LAST) begin
          cap_ts  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stall run length and read-latency countdown
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      lat_q   <= '0;
    end else begin
      if (avm_read && avm_waitrequest)
        stall_q <= stall_q + 16'd1;
      else
        stall_q <= '0;
      if (in_lat && !(cap_id || cap_ts))
        lat_q <= lat_q + 3'd1;
      else
        lat_q <= '0;
    end
  end

  // Captured words and verdict flags
  always_ff @(posedge clock) begin
    if (reset) begin
      id_value    <= '0;
      ts_value    <= '0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (launch) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) begin
        ts_value <= avm_readdata;
        id_ok    <= (id_value == EXPECTED_ID);
        ts_ok    <= (avm_readdata == EXPECTED_TS);
      end
      if (abort) begin
        timeout_err <= 1'b1;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_system_sysid_checker.sv
// Randomized bench for system_sysid_checker with a
// cycle-arithmetic reference model and reactive sysid slave.
module tb_system_sysid_checker;

  localparam logic [31:0] EID0 = 32'd0;
  localparam logic [31:0] ETS0 = 32'd1393616007;
  localparam logic [31:0] EID1 = 32'h1234_5678;
  localparam logic [31:0] ETS1 = 32'hCAFE_0001;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  start;
  logic [1:0]  wr;
  logic [31:0] rdata [2];
  logic [1:0]  addr_o, rd_o, busy_o, done_o;
  logic [1:0]  idok, tsok, terr;
  logic [31:0] idval [2];
  logic [31:0] tsval [2];

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] prev_id [2];
  logic [31:0] prev_ts [2];

  always #5 clock = ~clock;

  system_sysid_checker u0 (
    .clock(clock), .reset(reset), .start(start[0]),
    .avm_address(addr_o[0]), .avm_read(rd_o[0]),
    .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]),
    .busy(busy_o[0]), .done(done_o[0]),
    .id_ok(idok[0]), .ts_ok(tsok[0]),
    .timeout_err(terr[0]),
    .id_value(idval[0]), .ts_value(tsval[0])
  );

  system_sysid_checker #(
    .EXPECTED_ID(EID1), .EXPECTED_TS(ETS1),
    .READ_LATENCY(2), .TIMEOUT_CYCLES(4)
  ) u1 (
    .clock(clock), .reset(reset), .start(start[1]),
    .avm_address(addr_o[1]), .avm_read(rd_o[1]),
    .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]),
    .busy(busy_o[1]), .done(done_o[1]),
    .id_ok(idok[1]), .ts_ok(tsok[1]),
    .timeout_err(terr[1]),
    .id_value(idval[1]), .ts_value(tsval[1])
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic int lat_of(int i);
    return (i != 0) ? 2 : 0;
  endfunction

  function automatic int tmo_of(int i);
    return (i != 0) ? 4 : 255;
  endfunction

  function automatic logic [31:0] eid_of(int i);
    return (i != 0) ? EID1 : EID0;
  endfunction

  function automatic logic [31:0] ets_of(int i);
    return (i != 0) ? ETS1 : ETS0;
  endfunction

  task automatic chk_zero(int i, string tag);
    chk($sformatf("%s_ctl%0d", tag, i),
        {30'd0, rd_o[i], busy_o[i]}, 32'd0);
    chk($sformatf("%s_flg%0d", tag, i),
        {28'd0, done_o[i], idok[i], tsok[i], terr[i]},
        32'd0);
    chk($sformatf("%s_addr%0d", tag, i),
        {31'd0, addr_o[i]}, 32'd0);
    chk($sformatf("%s_id%0d", tag, i), idval[i], 32'd0);
    chk($sformatf("%s_ts%0d", tag, i), tsval[i], 32'd0);
  endtask

  // One check run: wid/wts are waitrequest cycles per word
  // (>= timeout means stuck), rst_at >= 0 pulses reset there.
  task automatic run(int i, int wid, int wts,
                     logic [31:0] idv, logic [31:0] tsv,
                     bit hold, int rst_at);
    int L, T, ts_start, id_end, ts_end, fin, last;
    int id_left, ts_left, due;
    bit id_to, ts_to, to;
    logic [31:0] dval, w_id, w_ts;
    logic w_iok, w_tok, rdv, av;
    string p;
    L = lat_of(i);
    T = tmo_of(i);
    id_to = (wid >= T);
    ts_to = !id_to && (wts >= T);
    to = id_to || ts_to;
    id_end = id_to ? T : 1 + wid;
    ts_start = 2 + wid + L;
    ts_end = ts_to ? ts_start + T - 1 : ts_start + wts;
    if (id_to) fin = 1 + T;
    else if (ts_to) fin = ts_start + T;
    else fin = ts_start + wts + 1 + L;
    w_id = id_to ? prev_id[i] : idv;
    w_ts = to ? prev_ts[i] : tsv;
    w_iok = !to && (idv == eid_of(i));
    w_tok = !to && (tsv == ets_of(i));
    last = (rst_at >= 0) ? rst_at + 1 : fin + 1;
    id_left = wid;
    ts_left = wts;
    due = -1;
    dval = '0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clock);
      p = $sformatf("u%0d_c%0d", i, c);
      if (rst_at >= 0 && c == rst_at + 1) begin
        reset = 1'b0;
        start[i] = 1'b0;
        wr[i] = 1'b0;
        chk_zero(0, {p, "_rst"});
        chk_zero(1, {p, "_rst"});
        for (int k = 0; k < 2; k++) begin
          prev_id[k] = '0;
          prev_ts[k] = '0;
        end
        return;
      end
      rdv = (c >= 1 && c <= id_end) ||
            (!id_to && c >= ts_start && c <= ts_end);
      chk({p, "_read"}, {31'd0, rd_o[i]}, {31'd0, rdv});
      if (rdv) begin
        av = (c >= ts_start);
        chk({p, "_addr"}, {31'd0, addr_o[i]},
            {31'd0, av});
      end
      chk({p, "_busy"}, {31'd0, busy_o[i]},
          {31'd0, (c >= 1 && c < fin)});
      chk({p, "_done"}, {31'd0, done_o[i]},
          {31'd0, (c == fin)});
      if (c == 1)
        chk({p, "_clr"}, {29'd0, idok[i], tsok[i], terr[i]},
            32'd0);
      if (c >= fin) begin
        chk({p, "_flags"},
            {29'd0, idok[i], tsok[i], terr[i]},
            {29'd0, w_iok, w_tok, to});
        chk({p, "_idv"}, idval[i], w_id);
        chk({p, "_tsv"}, tsval[i], w_ts);
      end
      start[i] = (c == 0) || (hold && c <= fin);
      reset = (c == rst_at);
      wr[i] = 1'b0;
      rdata[i] = $urandom;
      if (rd_o[i]) begin
        if (addr_o[i] ? (ts_left > 0) : (id_left > 0)) begin
          wr[i] = 1'b1;
          if (addr_o[i]) ts_left--;
          else id_left--;
        end else if (L == 0) begin
          rdata[i] = addr_o[i] ? tsv : idv;
        end else begin
          due = c + L;
          dval = addr_o[i] ? tsv : idv;
        end
      end
      if (c == due) rdata[i] = dval;
    end
    start[i] = 1'b0;
    prev_id[i] = w_id;
    prev_ts[i] = w_ts;
  endtask

  initial begin
    int i, wid, wts, gap;
    logic [31:0] v_id, v_ts;
    bit hold;
    reset = 1'b1;
    start = '0;
    wr = '0;
    rdata[0] = '0;
    rdata[1] = '0;
    for (int k = 0; k < 2; k++) begin
      prev_id[k] = '0;
      prev_ts[k] = '0;
    end
    repeat (3) @(negedge clock);
    chk_zero(0, "por");
    chk_zero(1, "por");
    reset = 1'b0;
    @(negedge clock);

    run(0, 0, 0, EID0, ETS0, 1'b0, -1);
    run(0, 0, 0, EID0, ETS0 + 32'd1, 1'b0, -1);
    run(0, 0, 0, EID0, ETS0, 1'b0, -1);
    run(0, 3, 0, EID0, ETS0, 1'b0, -1);
    run(0, 1000, 0, EID0, ETS0, 1'b0, -1);
    run(0, 0, 254, 32'h5, ETS0, 1'b0, -1);
    run(1, 0, 0, EID1, ETS1, 1'b0, -1);
    run(1, 3, 4, EID1, 32'h1, 1'b0, -1);
    run(0, 0, 0, EID0, ETS0, 1'b1, -1);
    run(1, 1, 2, EID1, ETS1, 1'b1, -1);
    run(0, 0, 1000, EID0, ETS0, 1'b0, 5);
    run(1, 2, 0, 32'hDEAD_BEEF, ETS1, 1'b0, -1);

    repeat (60) begin
      i = int'($urandom_range(1, 0));
      wid = int'($urandom_range(i != 0 ? 5 : 4, 0));
      wts = int'($urandom_range(i != 0 ? 5 : 4, 0));
      v_id = ($urandom_range(3, 0) == 0) ? $urandom : eid_of(i);
      v_ts = ($urandom_range(3, 0) == 0) ? $urandom : ets_of(i);
      hold = ($urandom_range(3, 0) == 0);
      run(i, wid, wts, v_id, v_ts, hold, -1);
      gap = int'($urandom_range(2, 0));
      repeat (gap) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
